// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, receiver state encoding and the
// clock divider calculation used by the receiver (and a future transmitter).
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // True when the clock divides evenly into BAUD*OVERSAMPLE ticks and the
    // oversample ratio leaves room for a 3-point mid-bit vote.
    function automatic bit div_params_ok(input int clk_hz, input int baud, input int os);
        int bit_clk;
        bit_clk = baud * os;
        return (os >= 4) && (os % 2 == 0) && (bit_clk > 0) &&
               (bit_clk <= clk_hz) && (clk_hz % bit_clk == 0);
    endfunction

    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        if (baud * os <= 0) begin
            return 1;
        end
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks, with a
// synchronous restart so the tick phase can be aligned to a line edge.
module uart_rx_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || i_restart) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: synchronizes rxd, recovers frames with a 3-sample
// mid-bit majority vote and hands bytes out on a valid/ready interface.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 96_000_000,
    parameter int BAUD          = 12_000_000,
    parameter int OVERSAMPLE    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV = calc_div(CLK_FREQUENCY, BAUD, OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    if (!div_params_ok(CLK_FREQUENCY, BAUD, OVERSAMPLE)) begin : g_bad_params
        $error("uart_rx_deframer: need integer CLK_FREQUENCY/(BAUD*OVERSAMPLE) >= 1, OVERSAMPLE even and >= 4");
    end

    logic [1:0]           r_sync;
    logic                 r_rxd_prev;
    rx_state_t            r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_samp_a;
    logic                 r_samp_b;
    logic                 r_frame_err;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_overrun;

    logic w_rxd_s;
    logic w_start_edge;
    logic w_tick;
    logic w_majority;
    logic w_decide;
    logic w_bit_end;
    logic w_commit;

    assign w_rxd_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync     <= 2'b11;
            r_rxd_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[0], rxd};
            r_rxd_prev <= w_rxd_s;
        end
    end

    assign w_start_edge = (r_state == IDLE) && r_rxd_prev && !w_rxd_s;

    uart_rx_tick #(.DIV(DIV)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .i_restart (w_start_edge),
        .o_tick    (w_tick)
    );

    // The edge-detect cycle is tick 0 of the start bit; the vote uses the two
    // stored samples plus the live sample at tick M+1.
    assign w_majority = (r_samp_a & r_samp_b) | (r_samp_a & w_rxd_s) | (r_samp_b & w_rxd_s);
    assign w_decide   = w_tick && (r_tick_cnt == TW'(M + 1));
    assign w_bit_end  = w_tick && (r_tick_cnt == TW'(OVERSAMPLE - 1));
    assign w_commit   = (r_state == STOP) && w_decide && w_majority;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_samp_a    <= 1'b1;
            r_samp_b    <= 1'b1;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if ((r_state == START || r_state == DATA || r_state == STOP) && w_tick) begin
                if (r_tick_cnt == TW'(M - 1)) r_samp_a <= w_rxd_s;
                if (r_tick_cnt == TW'(M))     r_samp_b <= w_rxd_s;
                r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + TW'(1);
            end
            case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        r_state    <= START;
                        r_tick_cnt <= TW'(1);
                        r_bit_cnt  <= '0;
                    end
                end
                START: begin
                    if (w_decide && w_majority) begin
                        r_state <= IDLE;
                    end else if (w_bit_end) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_decide) begin
                        r_shift <= {w_majority, r_shift[DATA_BITS-1:1]};
                    end
                    if (w_bit_end) begin
                        if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end
                end
                STOP: begin
                    if (w_decide) begin
                        if (w_majority) begin
                            r_state <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (w_rxd_s) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A byte landing in the same cycle as a handshake replaces the old one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_commit) begin
                if (!r_valid || data_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed and randomized frames for uart_rx_deframer at default parameters,
// scored against a frame-level model of what the line should deliver.
module tb_uart_rx_deframer;

    localparam int BIT_CYC = 96_000_000 / 12_000_000;
    // Pin edge that starts a frame to the edge that raises data_valid.
    localparam int COMMIT_EDGE = 2 + 9 * BIT_CYC + 5 + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int n_hs = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int hs0, f0, o0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_deframer dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every handshake must deliver the oldest expected byte.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (data_valid && data_ready) begin
                logic [31:0] exp_b;
                n_hs++;
                exp_b = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
                check("hs_data", 32'(data_out), exp_b);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        rxd = 1'b0;
        repeat (BIT_CYC) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT_CYC) @(posedge clk);
            #1;
        end
        rxd = stop_ok;
        repeat (BIT_CYC) @(posedge clk);
        #1;
    endtask

    task automatic line_level(input logic lvl, input int n);
        rxd = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snapshot();
        hs0 = n_hs;
        f0  = n_ferr;
        o0  = n_ovr;
    endtask

    initial begin
        int seen;
        int back_at;
        int n_good;
        int n_bad;
        logic [7:0] b;
        logic bad;

        rxd = 1'b1;
        data_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;

        // Back-to-back frames with no idle between them.
        snapshot();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hBB);
        send_frame(8'hAA, 1'b1);
        send_frame(8'hBB, 1'b1);
        line_level(1'b1, 4 * BIT_CYC);
        check("b2b_handshakes", 32'(n_hs - hs0), 32'd2);
        check("b2b_frame_err", 32'(n_ferr - f0), 32'd0);
        check("b2b_overrun", 32'(n_ovr - o0), 32'd0);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Two-cycle low glitch must be rejected by the start-bit vote.
        snapshot();
        line_level(1'b0, 2);
        rxd = 1'b1;
        seen = 0;
        back_at = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (busy) seen = 1;
            if (seen != 0 && !busy && back_at < 0) back_at = i;
        end
        check("glitch_busy_seen", 32'(seen), 32'd1);
        check("glitch_busy_clear", 32'(back_at >= 0 && back_at <= 8), 32'd1);
        @(posedge clk);
        #1;
        line_level(1'b1, BIT_CYC);
        check("glitch_no_byte", 32'(n_hs - hs0), 32'd0);
        check("glitch_no_ferr", 32'(n_ferr - f0), 32'd0);

        // Bad stop bit, long break, then a clean frame.
        snapshot();
        exp_q.push_back(8'h55);
        send_frame(8'h3C, 1'b0);
        line_level(1'b0, 20 * BIT_CYC);
        line_level(1'b1, 2 * BIT_CYC);
        send_frame(8'h55, 1'b1);
        line_level(1'b1, 2 * BIT_CYC);
        check("break_one_ferr", 32'(n_ferr - f0), 32'd1);
        check("break_one_byte", 32'(n_hs - hs0), 32'd1);
        check("break_overrun", 32'(n_ovr - o0), 32'd0);
        check("break_queue_empty", 32'(exp_q.size()), 32'd0);

        // Second byte arrives while the first is still held.
        data_ready = 1'b0;
        snapshot();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        line_level(1'b1, BIT_CYC);
        send_frame(8'h22, 1'b1);
        line_level(1'b1, BIT_CYC);
        @(negedge clk);
        check("ovr_data_held", 32'(data_out), 32'h11);
        check("ovr_valid_held", 32'(data_valid), 32'h1);
        check("ovr_one_pulse", 32'(n_ovr - o0), 32'd1);
        check("ovr_no_hs_yet", 32'(n_hs - hs0), 32'd0);
        @(posedge clk);
        #1 data_ready = 1'b1;
        @(posedge clk);
        #1 data_ready = 1'b0;
        @(negedge clk);
        check("ovr_valid_drop", 32'(data_valid), 32'h0);
        check("ovr_hs_count", 32'(n_hs - hs0), 32'd1);
        check("ovr_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Handshake of the held byte in the very cycle the next one commits.
        snapshot();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        line_level(1'b1, BIT_CYC);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (COMMIT_EDGE - 1) @(posedge clk);
                #1 data_ready = 1'b1;
                @(posedge clk);
                #1 data_ready = 1'b0;
                @(negedge clk);
                check("same_cycle_data", 32'(data_out), 32'h22);
                check("same_cycle_valid", 32'(data_valid), 32'h1);
            end
        join
        @(posedge clk);
        #1;
        check("same_cycle_no_ovr", 32'(n_ovr - o0), 32'd0);
        check("same_cycle_hs", 32'(n_hs - hs0), 32'd1);
        data_ready = 1'b1;
        line_level(1'b1, 2);
        check("same_cycle_drained", 32'(exp_q.size()), 32'd0);

        // Reset during data bit 4 abandons the frame silently.
        snapshot();
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (2 + 5 * BIT_CYC + 1) @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                @(negedge clk);
                check("mid_rst_data_out", 32'(data_out), 32'h00);
                check("mid_rst_valid", 32'(data_valid), 32'h0);
                check("mid_rst_busy", 32'(busy), 32'h0);
                check("mid_rst_ferr", 32'(frame_err), 32'h0);
                check("mid_rst_ovr", 32'(overrun), 32'h0);
            end
        join
        line_level(1'b1, BIT_CYC);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        line_level(1'b1, 2 * BIT_CYC);
        check("post_rst_hs", 32'(n_hs - hs0), 32'd1);
        check("post_rst_ferr", 32'(n_ferr - f0), 32'd0);
        check("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

        // Random bytes, random gaps, occasional glitches and broken stop bits.
        snapshot();
        n_good = 0;
        n_bad = 0;
        for (int f = 0; f < 16; f++) begin
            b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 4) == 0) begin
                line_level(1'b0, $urandom_range(1, 3));
                line_level(1'b1, 12);
            end
            if (bad) begin
                n_bad++;
            end else begin
                n_good++;
                exp_q.push_back(b);
            end
            send_frame(b, !bad);
            if (bad) begin
                line_level(1'b0, $urandom_range(1, 3) * BIT_CYC);
                line_level(1'b1, BIT_CYC);
            end
            line_level(1'b1, $urandom_range(0, 20));
        end
        line_level(1'b1, 4 * BIT_CYC);
        check("rand_hs_count", 32'(n_hs - hs0), 32'(n_good));
        check("rand_ferr_count", 32'(n_ferr - f0), 32'(n_bad));
        check("rand_overrun", 32'(n_ovr - o0), 32'd0);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rand_idle_busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
